mem_stage: RTL and testbench



---
 rtl/dlx_mem_pkg.sv | 46 ++++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX memory stage: load/store opcodes, FSM
// states, access sizes and the opcode decoder used by the top and aligner.
package dlx_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;

  typedef struct packed {
    size_e size;
    logic  sign;
  } mem_op_t;

  // Anything that is not a sub-word opcode is treated as a full word access.
  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t r;
    r.size = WORD;
    r.sign = 1'b0;
    case (op)
      OP_LB:         begin r.size = BYTE; r.sign = 1'b1; end
      OP_LH:         begin r.size = HALF; r.sign = 1'b1; end
      OP_LBU, OP_SB: r.size = BYTE;
      OP_LHU, OP_SH: r.size = HALF;
      default:       r.size = WORD;
    endcase
    return r;
  endfunction

  function automatic logic is_aligned(input size_e size, input logic [1:0] lo);
    case (size)
      BYTE:    return 1'b1;
      HALF:    return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Big-endian load extraction: picks the addressed byte or half out of the
// read word and sign- or zero-extends it to 32 bits.
module mem_load_align
  import dlx_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[31:24];
      2'd1:    byte_sel = rdata_i[23:16];
      2'd2:    byte_sel = rdata_i[15:8];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    case (size_i)
      BYTE:    data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      HALF:    data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// DLX memory stage: drives a variable-latency data memory over req/ready,
// stalls upstream while an access is outstanding and loads the MEM/WB register.
module mem_stage
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] Result,
  input  logic [31:0] mem_data_ex,
  input  logic [5:0]  opcode_ex,
  input  logic [4:0]  towrite_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic        RegWrite_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic [31:0] result_mem,
  output logic [4:0]  towrite_mem,
  output logic        RegWrite_mem,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_op_t       dec;
  logic          access, aligned, timeout_hit, req, complete;
  logic [31:0]   wdata, load_data;
  logic [3:0]    be;
  logic [31:0]   result_q, result_d;
  logic [4:0]    towrite_q, towrite_d;
  logic          regwr_q, regwr_d, align_q, bus_q;

  assign dec         = decode_op(opcode_ex);
  assign access      = valid_ex & (MemtoReg_ex | MemWrite_ex);
  assign aligned     = is_aligned(dec.size, Result[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && (state_q == WAIT) && (cnt_q == TO_V);
  // Gating with rst_n drops an outstanding request the instant reset asserts.
  assign req         = rst_n & access & aligned & ~timeout_hit;
  assign complete    = req & dmem_ready;
  assign mem_stall   = req & ~dmem_ready;

  always_comb begin
    wdata = mem_data_ex;
    be    = 4'b1111;
    case (dec.size)
      BYTE: begin
        wdata = {4{mem_data_ex[7:0]}};
        be    = 4'b1000 >> Result[1:0];
      end
      HALF: begin
        wdata = {2{mem_data_ex[15:0]}};
        be    = Result[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  assign dmem_req   = req;
  assign dmem_we    = req & MemWrite_ex;
  assign dmem_addr  = req ? {Result[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = req ? wdata : 32'h0;
  assign dmem_be    = req ? be : 4'b0000;

  mem_load_align u_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (Result[1:0]),
    .size_i    (dec.size),
    .sign_i    (dec.sign),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter tracks stall cycles so far; the issue cycle counts as the first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_stall) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (mem_stall) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Any access that is not completing this cycle loads a bubble.
  always_comb begin
    result_d  = Result;
    towrite_d = towrite_ex;
    regwr_d   = RegWrite_ex & valid_ex;
    if (access) begin
      regwr_d = 1'b0;
      if (complete & ~MemWrite_ex) begin
        result_d = load_data;
        regwr_d  = RegWrite_ex;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      towrite_q <= '0;
      regwr_q   <= 1'b0;
      align_q   <= 1'b0;
      bus_q     <= 1'b0;
    end else begin
      result_q  <= result_d;
      towrite_q <= towrite_d;
      regwr_q   <= regwr_d;
      align_q   <= access & ~aligned;
      bus_q     <= timeout_hit;
    end
  end

  assign result_mem   = result_q;
  assign towrite_mem  = towrite_q;
  assign RegWrite_mem = regwr_q;
  assign align_err    = align_q;
  assign bus_err      = bus_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a byte-lane reference model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        valid_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex;
  logic [31:0] Result, mem_data_ex, dmem_rdata;
  logic [5:0]  opcode_ex;
  logic [4:0]  towrite_ex;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, mem_stall, RegWrite_mem, align_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, result_mem;
  logic [3:0]  dmem_be;
  logic [4:0]  towrite_mem;

  int checks = 0;
  int passes = 0;

  logic [5:0] ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .Result(Result),
    .mem_data_ex(mem_data_ex), .opcode_ex(opcode_ex), .towrite_ex(towrite_ex),
    .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .mem_stall(mem_stall), .result_mem(result_mem),
    .towrite_mem(towrite_mem), .RegWrite_mem(RegWrite_mem),
    .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] model_load(int sz, bit sgn, logic [31:0] a, logic [31:0] rd);
    int k = int'(a % 4);
    longint v;
    if (sz == 4) return rd;
    if (sz == 1) v = longint'((rd >> (8 * (3 - k))) & 32'hFF);
    else         v = longint'((rd >> (16 * (1 - k / 2))) & 32'hFFFF);
    if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(int sz, logic [31:0] a);
    logic [3:0] m = 4'b0000;
    int off = int'(a % 4);
    for (int k = 0; k < 4; k++) if (k >= off && k < off + sz) m[3-k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(int sz, logic [31:0] d);
    logic [31:0] w = 32'h0;
    for (int k = 0; k < 4; k++) w = (w << 8) | ((d >> (8 * (sz - 1 - (k % sz)))) & 32'hFF);
    return w;
  endfunction

  task automatic idle_inputs();
    valid_ex = 0; MemWrite_ex = 0; MemtoReg_ex = 0; RegWrite_ex = 1;
    dmem_ready = 0; opcode_ex = 6'h00;
  endtask

  task automatic do_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdat, input int lat, input bit gap,
                           output logic req0, output logic [3:0] be0, output logic [31:0] wd0,
                           output logic [31:0] res, output logic rw, output int stalls);
    int sz; bit sgn, st, ok, exp_req, exp_stall;
    logic [31:0] exp_res;
    logic [4:0] rd;
    sz = 4; sgn = 0; st = 0;
    case (op)
      6'h20: begin sz = 1; sgn = 1; end
      6'h21: begin sz = 2; sgn = 1; end
      6'h24: sz = 1;
      6'h25: sz = 2;
      6'h28: begin sz = 1; st = 1; end
      6'h29: begin sz = 2; st = 1; end
      6'h2B: st = 1;
      default: ;
    endcase
    ok = (addr % sz) == 0;
    exp_res = model_load(sz, sgn, addr, rdat);
    rd = 5'($urandom);
    stalls = 0; req0 = 0; be0 = 0; wd0 = 0;
    @(negedge clk);
    valid_ex = 1; Result = addr; mem_data_ex = data; opcode_ex = op; towrite_ex = rd;
    MemWrite_ex = st; MemtoReg_ex = !st; RegWrite_ex = !st;
    for (int c = 0; c <= TO; c++) begin
      if (c > 0) @(negedge clk);
      dmem_ready = (c == lat);
      dmem_rdata = (c == lat) ? rdat : $urandom;
      #1;
      exp_req = ok && (c < TO);
      exp_stall = exp_req && (c != lat);
      if (c == 0) begin req0 = dmem_req; be0 = dmem_be; wd0 = dmem_wdata; end
      if (mem_stall === 1'b1) stalls++;
      checks++; if (dmem_req !== exp_req) $display("FAIL req op=%h c=%0d: got %b required %b", op, c, dmem_req, exp_req); else passes++;
      checks++; if (mem_stall !== exp_stall) $display("FAIL stall op=%h c=%0d: got %b required %b", op, c, mem_stall, exp_stall); else passes++;
      if (exp_req) begin
        checks++; if (dmem_addr !== (addr & ~32'h3)) $display("FAIL addr: got %h required %h", dmem_addr, addr & ~32'h3); else passes++;
        checks++; if (dmem_we !== st) $display("FAIL we: got %b required %b", dmem_we, st); else passes++;
        if (st) begin
          checks++; if (dmem_be !== model_be(sz, addr)) $display("FAIL be op=%h a=%h: got %b required %b", op, addr, dmem_be, model_be(sz, addr)); else passes++;
          checks++; if (dmem_wdata !== model_wdata(sz, data)) $display("FAIL wdata op=%h: got %h required %h", op, dmem_wdata, model_wdata(sz, data)); else passes++;
        end
      end
      @(posedge clk); #1;
      if (!ok) begin
        checks++; if (align_err !== 1'b1) $display("FAIL align_err: got %b required 1", align_err); else passes++;
        checks++; if (RegWrite_mem !== 1'b0) $display("FAIL misaligned regwrite: got %b required 0", RegWrite_mem); else passes++;
        break;
      end else if (exp_req && c == lat) begin
        checks++; if (RegWrite_mem !== !st) $display("FAIL done regwrite op=%h: got %b required %b", op, RegWrite_mem, !st); else passes++;
        if (!st) begin
          checks++; if (result_mem !== exp_res) $display("FAIL load data op=%h a=%h: got %h required %h", op, addr, result_mem, exp_res); else passes++;
          checks++; if (towrite_mem !== rd) $display("FAIL towrite: got %0d required %0d", towrite_mem, rd); else passes++;
        end
        checks++; if (bus_err !== 1'b0) $display("FAIL bus_err on done: got %b required 0", bus_err); else passes++;
        break;
      end else if (exp_req) begin
        checks++; if (RegWrite_mem !== 1'b0) $display("FAIL stall regwrite c=%0d: got %b required 0", c, RegWrite_mem); else passes++;
      end else begin
        checks++; if (bus_err !== 1'b1) $display("FAIL bus_err: got %b required 1", bus_err); else passes++;
        checks++; if (RegWrite_mem !== 1'b0) $display("FAIL abort regwrite: got %b required 0", RegWrite_mem); else passes++;
        break;
      end
    end
    res = result_mem; rw = RegWrite_mem;
    if (gap) begin
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      checks++; if (align_err !== 1'b0 || bus_err !== 1'b0) $display("FAIL pulse width: got %b%b required 00", align_err, bus_err); else passes++;
      checks++; if (RegWrite_mem !== 1'b0) $display("FAIL repeat writeback: got %b required 0", RegWrite_mem); else passes++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1; idle_inputs();
    valid_ex = 1; MemtoReg_ex = 1; opcode_ex = 6'h23; Result = 32'h100; mem_data_ex = 32'hFFFFFFFF;
    towrite_ex = 5'd7; dmem_rdata = 32'h0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if ({dmem_req, dmem_we, mem_stall, RegWrite_mem, align_err, bus_err} !== 6'b0) $display("FAIL reset ctrl: got %b required 000000", {dmem_req, dmem_we, mem_stall, RegWrite_mem, align_err, bus_err}); else passes++;
    checks++; if ({dmem_addr, dmem_wdata, dmem_be} !== 68'h0) $display("FAIL reset bus: got %h required 0", {dmem_addr, dmem_wdata, dmem_be}); else passes++;
    checks++; if ({result_mem, towrite_mem} !== 37'h0) $display("FAIL reset memwb: got %h required 0", {result_mem, towrite_mem}); else passes++;
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_directed();
    logic r0, rw; logic [3:0] b0; logic [31:0] w0, res; int st;
    do_access(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, r0, b0, w0, res, rw, st);
    checks++; if (r0 !== 1'b1 || b0 !== 4'b1111 || st != 0) $display("FAIL lw issue: got req=%b be=%b stalls=%0d required 1 1111 0", r0, b0, st); else passes++;
    checks++; if (res !== 32'hDEADBEEF || rw !== 1'b1) $display("FAIL lw result: got %h/%b required deadbeef/1", res, rw); else passes++;
    do_access(6'h20, 32'h103, 32'h0, 32'h000000F0, 0, 1, r0, b0, w0, res, rw, st);
    checks++; if (res !== 32'hFFFFFFF0) $display("FAIL lb sext: got %h required fffffff0", res); else passes++;
    do_access(6'h24, 32'h103, 32'h0, 32'h000000F0, 0, 1, r0, b0, w0, res, rw, st);
    checks++; if (res !== 32'h000000F0) $display("FAIL lbu zext: got %h required 000000f0", res); else passes++;
    do_access(6'h29, 32'h202, 32'h1234ABCD, 32'h0, 0, 1, r0, b0, w0, res, rw, st);
    checks++; if (b0 !== 4'b0011 || w0 !== 32'hABCDABCD || rw !== 1'b0) $display("FAIL sh: got be=%b wd=%h rw=%b required 0011 abcdabcd 0", b0, w0, rw); else passes++;
    do_access(6'h21, 32'h101, 32'h0, 32'h0, 0, 1, r0, b0, w0, res, rw, st);
    checks++; if (r0 !== 1'b0 || rw !== 1'b0) $display("FAIL lh misaligned: got req=%b rw=%b required 0 0", r0, rw); else passes++;
  endtask

  task automatic test_wait_states();
    logic r0, rw; logic [3:0] b0; logic [31:0] w0, res; int st;
    do_access(6'h23, 32'h40, 32'h0, 32'hCAFEF00D, 3, 1, r0, b0, w0, res, rw, st);
    checks++; if (st != 3 || res !== 32'hCAFEF00D || rw !== 1'b1) $display("FAIL lw 3-wait: got stalls=%0d res=%h rw=%b required 3 cafef00d 1", st, res, rw); else passes++;
    do_access(6'h23, 32'h44, 32'h0, 32'h1, 1000, 1, r0, b0, w0, res, rw, st);
    checks++; if (st != TO || rw !== 1'b0) $display("FAIL timeout: got stalls=%0d rw=%b required %0d 0", st, rw, TO); else passes++;
  endtask

  task automatic test_nonaccess();
    logic v, w; logic [31:0] r; logic [4:0] d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v = 1'($urandom); w = 1'($urandom); r = $urandom; d = 5'($urandom);
      valid_ex = v; RegWrite_ex = w; Result = r; towrite_ex = d; opcode_ex = 6'h00;
      MemWrite_ex = 0; MemtoReg_ex = 0; dmem_ready = 1'($urandom);
      #1;
      checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL alu req/stall: got %b%b required 00", dmem_req, mem_stall); else passes++;
      @(posedge clk); #1;
      checks++; if (result_mem !== r || towrite_mem !== d || RegWrite_mem !== (v & w)) $display("FAIL alu memwb: got %h/%0d/%b required %h/%0d/%b", result_mem, towrite_mem, RegWrite_mem, r, d, v & w); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic r0, rw; logic [3:0] b0; logic [31:0] w0, res; int st;
    do_access(6'h23, 32'h80, 32'h0, 32'h11223344, 0, 0, r0, b0, w0, res, rw, st);
    do_access(6'h21, 32'h86, 32'h0, 32'h0000F123, 0, 0, r0, b0, w0, res, rw, st);
    checks++; if (r0 !== 1'b1 || res !== 32'hFFFFF123) $display("FAIL b2b lh: got req=%b res=%h required 1 fffff123", r0, res); else passes++;
    do_access(6'h28, 32'h89, 32'h000000A5, 32'h0, 2, 0, r0, b0, w0, res, rw, st);
    do_access(6'h25, 32'h8A, 32'h0, 32'h0000F123, 0, 1, r0, b0, w0, res, rw, st);
    checks++; if (r0 !== 1'b1 || res !== 32'h0000F123) $display("FAIL b2b lhu: got req=%b res=%h required 1 0000f123", r0, res); else passes++;
  endtask

  task automatic test_random();
    logic r0, rw; logic [3:0] b0; logic [31:0] w0, res; int st;
    for (int i = 0; i < 40; i++)
      do_access(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                int'($urandom_range(0, 5)), 1'($urandom), r0, b0, w0, res, rw, st);
  endtask

  task automatic test_reset_mid_wait();
    logic r0, rw; logic [3:0] b0; logic [31:0] w0, res; int st;
    do_access(6'h23, 32'h300, 32'h0, 32'h55AA55AA, 0, 0, r0, b0, w0, res, rw, st);
    @(negedge clk);
    valid_ex = 1; MemtoReg_ex = 1; MemWrite_ex = 0; RegWrite_ex = 1; opcode_ex = 6'h23;
    Result = 32'h304; dmem_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) $display("FAIL pre-reset wait: got %b%b required 11", dmem_req, mem_stall); else passes++;
    #2 rst_n = 0;
    #1;
    checks++; if ({dmem_req, dmem_we, mem_stall, RegWrite_mem, align_err, bus_err} !== 6'b0) $display("FAIL async reset ctrl: got %b required 000000", {dmem_req, dmem_we, mem_stall, RegWrite_mem, align_err, bus_err}); else passes++;
    checks++; if ({result_mem, towrite_mem, dmem_addr, dmem_be} !== 73'h0) $display("FAIL async reset data: got %h required 0", {result_mem, towrite_mem, dmem_addr, dmem_be}); else passes++;
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    do_access(6'h23, 32'h308, 32'h0, 32'h0BADC0DE, 3, 1, r0, b0, w0, res, rw, st);
    checks++; if (st != 3 || res !== 32'h0BADC0DE) $display("FAIL post-reset access: got stalls=%0d res=%h required 3 0badc0de", st, res); else passes++;
  endtask

  initial begin
    Result = 0; mem_data_ex = 0; towrite_ex = 0; dmem_rdata = 0;
    test_reset();
    test_directed();
    test_wait_states();
    test_nonaccess();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
